// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE,
    ERROR
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // Divide first so large timeouts at high clock rates stay inside 32 bits.
  function automatic int us_to_cycles(input int freq_hz, input int us);
    return (freq_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line with a registered falling-edge pulse.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_fall;

  // Idle bus level is high; resetting to 1 avoids a false edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fall <= r_prev & ~r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, shift, ACK check).
// Define PS2_HOST_TX_TIMEOUT_EN to enable the device-clock watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_US  = 15_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int INH_W   = $clog2(INH_CYC) + 1;
  localparam int TO_CYC  = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int TO_W    = $clog2(TO_CYC) + 1;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_data_fall_unused;
  logic w_timeout;

  ps2_state_e       r_state;
  logic             r_tx_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic [7:0]       r_shreg;
  logic             r_parity;
  logic [3:0]       r_bit_cnt;
  logic [INH_W-1:0] r_inh_cnt;

  ps2_sync_edge u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .i_pin (ps2_clk_in),
    .o_sync(w_clk_sync),
    .o_fall(w_clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .i_pin (ps2_data_in),
    .o_sync(w_data_sync),
    .o_fall(w_data_fall_unused)
  );

`ifdef PS2_HOST_TX_TIMEOUT_EN
  logic [TO_W-1:0] r_wdog;
  logic            w_wdog_run;

  assign w_wdog_run = (r_state == SHIFT) || (r_state == ACK) || (r_state == WAIT_IDLE);
  assign w_timeout  = w_wdog_run && (r_wdog == TO_W'(TO_CYC - 1));

  // Held at zero outside the clocked phases, so it is clear on entry to SHIFT.
  always_ff @(posedge clk) begin
    if (rst || !w_wdog_run || w_clk_fall) r_wdog <= '0;
    else if (r_wdog != {TO_W{1'b1}})      r_wdog <= r_wdog + 1'b1;
  end
`else
  logic w_cfg_unused;
  assign w_cfg_unused = ^TO_W'(TO_CYC);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_shreg    <= '0;
      r_parity   <= 1'b0;
      r_bit_cnt  <= '0;
      r_inh_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          if (tx_valid && r_tx_ready) begin
            r_shreg    <= tx_data;
            r_parity   <= ~^tx_data;
            r_inh_cnt  <= '0;
            r_clk_oe   <= 1'b1;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_inh_cnt == INH_W'(INH_CYC - 1)) begin
            r_data_oe <= 1'b1;
            r_state   <= START;
          end else if (r_inh_cnt != {INH_W{1'b1}}) begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end
        START: begin
          r_clk_oe  <= 1'b0;
          r_bit_cnt <= '0;
          r_state   <= SHIFT;
        end
        SHIFT: begin
          // Each device falling edge presents the next bit; the device samples on the rise.
          if (w_clk_fall) begin
            if (r_bit_cnt < 4'd8)       r_data_oe <= ~r_shreg[r_bit_cnt[2:0]];
            else if (r_bit_cnt == 4'd8) r_data_oe <= ~r_parity;
            else                        r_data_oe <= 1'b0;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 4'd9) r_state <= ACK;
          end else if (w_timeout) begin
            r_err <= 1'b1; r_clk_oe <= 1'b0; r_data_oe <= 1'b0; r_state <= ERROR;
          end
        end
        ACK: begin
          if (w_clk_fall) begin
            if (w_data_sync) begin
              r_err <= 1'b1; r_clk_oe <= 1'b0; r_data_oe <= 1'b0; r_state <= ERROR;
            end else begin
              r_state <= WAIT_IDLE;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1; r_clk_oe <= 1'b0; r_data_oe <= 1'b0; r_state <= ERROR;
          end
        end
        WAIT_IDLE: begin
          if (w_clk_sync && w_data_sync) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_err <= 1'b1; r_clk_oe <= 1'b0; r_data_oe <= 1'b0; r_state <= ERROR;
          end
        end
        ERROR: begin
          r_clk_oe   <= 1'b0;
          r_data_oe  <= 1'b0;
          r_busy     <= 1'b0;
          r_tx_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = r_tx_ready;
  assign tx_busy     = r_busy;
  assign tx_done     = r_done;
  assign tx_error    = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule
